// File: rtl/led_pattern_sequencer_if.sv
// ---------------------------------------------------------------------------
// led_pattern_sequencer_if
//   Groups the board-facing signals of the LED pattern sequencer.
//
//   BTN    push-button, active-high, asynchronous to CLK
//   PAUSE  1 freezes the step timer and the pattern
//   DIP    [0] step speed select (0 fast, 1 slow), [1] auto-cycle enable
//   LED    active-low LED bank drive
//   MODE   current pattern mode
//   STEP   one-cycle pulse on each pattern update
//
//   master : the board / stimulus side (drives BTN, PAUSE, DIP)
//   slave  : the sequencer (drives LED, MODE, STEP)
// ---------------------------------------------------------------------------
interface led_pattern_sequencer_if;
    logic        BTN;
    logic        PAUSE;
    logic [1:0]  DIP;
    logic [15:0] LED;
    logic [1:0]  MODE;
    logic        STEP;

    modport master (
        output BTN,
        output PAUSE,
        output DIP,
        input  LED,
        input  MODE,
        input  STEP
    );

    modport slave (
        input  BTN,
        input  PAUSE,
        input  DIP,
        output LED,
        output MODE,
        output STEP
    );
endinterface

// File: rtl/led_pattern_sequencer.sv
// ---------------------------------------------------------------------------
// led_pattern_sequencer
//   Single-clock controller for the 16-LED bank. A free-running step timer
//   produces a clock enable; on each enable the pattern P advances according
//   to the current mode (rotate left, rotate right, bounce, fill). A debounced
//   push-button, or an automatic advance after STEPS_PER_MODE steps, moves to
//   the next mode and restarts the pattern from 16'h0001.
//
// Ports
//   CLK    system clock
//   RESET  asynchronous, active-low reset
//   bus    slave modport of led_pattern_sequencer_if:
//            BTN, PAUSE, DIP in; LED (= ~P), MODE, STEP out, all registered
//
// Parameters
//   FAST_DIV        CLK cycles per step with DIP[0]=0 (>= 2)
//   SLOW_DIV        CLK cycles per step with DIP[0]=1 (>= 2)
//   DEB_CYCLES      consecutive stable cycles to accept a new button level
//   STEPS_PER_MODE  steps per mode before an auto-advance (>= 1)
// ---------------------------------------------------------------------------
module led_pattern_sequencer #(
    parameter int FAST_DIV       = 2097152,
    parameter int SLOW_DIV       = 8388608,
    parameter int DEB_CYCLES     = 65536,
    parameter int STEPS_PER_MODE = 32
) (
    input  logic                   CLK,
    input  logic                   RESET,
    led_pattern_sequencer_if.slave bus
);

    localparam int MAX_DIV = (FAST_DIV > SLOW_DIV) ? FAST_DIV : SLOW_DIV;
    localparam int CNT_W   = $clog2(MAX_DIV);
    localparam int DEB_W   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int STEP_W  = (STEPS_PER_MODE > 1) ? $clog2(STEPS_PER_MODE) : 1;

    localparam logic [CNT_W-1:0]  FAST_LIM = CNT_W'(FAST_DIV - 1);
    localparam logic [CNT_W-1:0]  SLOW_LIM = CNT_W'(SLOW_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_LIM  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [STEP_W-1:0] STEP_LIM = STEP_W'(STEPS_PER_MODE - 1);

    localparam logic [15:0] PAT_INIT = 16'h0001;

    typedef enum logic [1:0] {
        ROT_L  = 2'd0,
        ROT_R  = 2'd1,
        BOUNCE = 2'd2,
        FILL   = 2'd3
    } mode_t;

    localparam logic DIR_L = 1'b0;
    localparam logic DIR_R = 1'b1;

    // -----------------------------------------------------------------------
    // Pattern helpers
    // -----------------------------------------------------------------------
    function automatic logic [15:0] next_pat(input mode_t mode,
                                             input logic [15:0] p,
                                             input logic dir);
        case (mode)
            ROT_L:   next_pat = {p[14:0], p[15]};
            ROT_R:   next_pat = {p[0], p[15:1]};
            // Reversal happens on the step that leaves an end position, so
            // each end LED is lit for exactly one step (30-step period).
            BOUNCE: begin
                if (dir == DIR_L) next_pat = p[15] ? (p >> 1) : (p << 1);
                else              next_pat = p[0]  ? (p << 1) : (p >> 1);
            end
            default: next_pat = (p == 16'hFFFF) ? PAT_INIT : {p[14:0], 1'b1};
        endcase
    endfunction

    function automatic logic next_dir(input mode_t mode,
                                      input logic [15:0] p,
                                      input logic dir);
        next_dir = dir;
        if (mode == BOUNCE) begin
            if (dir == DIR_L && p[15])     next_dir = DIR_R;
            else if (dir == DIR_R && p[0]) next_dir = DIR_L;
        end
    endfunction

    function automatic mode_t next_mode(input mode_t mode);
        case (mode)
            ROT_L:   next_mode = ROT_R;
            ROT_R:   next_mode = BOUNCE;
            BOUNCE:  next_mode = FILL;
            default: next_mode = ROT_L;
        endcase
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [CNT_W-1:0]  tick_cnt,  tick_cnt_d;
    logic              step_q,    step_d;
    logic [15:0]       pat_q,     pat_d;
    logic [15:0]       led_q,     led_d;
    mode_t             mode_q,    mode_d;
    logic              dir_q,     dir_d;
    logic [STEP_W-1:0] step_cnt,  step_cnt_d;
    logic              sync_a,    sync_b;
    logic [DEB_W-1:0]  deb_cnt,   deb_cnt_d;
    logic              deb_lvl,   deb_lvl_d;
    logic              press_q,   press_d;

    logic [CNT_W-1:0]  div_lim;
    logic              tick;
    logic              auto_adv;
    logic              advance;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        div_lim    = bus.DIP[0] ? SLOW_LIM : FAST_LIM;
        // ">=" rather than "==" so a switch to the faster rate while the
        // count is already past the new limit still ticks immediately.
        tick       = !bus.PAUSE && (tick_cnt >= div_lim);
        // step_q marks the cycle the last step became visible; the advance
        // therefore lands one cycle after the STEPS_PER_MODE-th STEP pulse.
        auto_adv   = bus.DIP[1] && step_q && (step_cnt == STEP_LIM);
        // Press and auto-advance share one path, so coincident events merge.
        advance    = press_q || auto_adv;

        tick_cnt_d = tick_cnt;
        step_d     = 1'b0;
        pat_d      = pat_q;
        dir_d      = dir_q;
        mode_d     = mode_q;
        step_cnt_d = step_cnt;
        deb_cnt_d  = deb_cnt;
        deb_lvl_d  = deb_lvl;
        press_d    = 1'b0;

        // Step timer and pattern; an advance wins over a coincident tick.
        if (advance) begin
            tick_cnt_d = '0;
            mode_d     = next_mode(mode_q);
            pat_d      = PAT_INIT;
            dir_d      = DIR_L;
        end else if (!bus.PAUSE) begin
            if (tick) begin
                tick_cnt_d = '0;
                step_d     = 1'b1;
                pat_d      = next_pat(mode_q, pat_q, dir_q);
                dir_d      = next_dir(mode_q, pat_q, dir_q);
            end else begin
                tick_cnt_d = tick_cnt + 1'b1;
            end
        end

        led_d = ~pat_d;

        // Steps taken in the current mode; only meaningful with auto-cycle.
        if (advance || !bus.DIP[1]) begin
            step_cnt_d = '0;
        end else if (step_q) begin
            step_cnt_d = step_cnt + 1'b1;
        end

        // Debounce: count consecutive cycles the synchronized level differs
        // from the accepted level; any agreement restarts the count.
        if (sync_b == deb_lvl) begin
            deb_cnt_d = '0;
        end else if (deb_cnt == DEB_LIM) begin
            deb_cnt_d = '0;
            deb_lvl_d = sync_b;
            press_d   = sync_b;
        end else begin
            deb_cnt_d = deb_cnt + 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            tick_cnt <= '0;
            step_q   <= 1'b0;
            pat_q    <= PAT_INIT;
            led_q    <= ~PAT_INIT;
            mode_q   <= ROT_L;
            dir_q    <= DIR_L;
            step_cnt <= '0;
            sync_a   <= 1'b0;
            sync_b   <= 1'b0;
            deb_cnt  <= '0;
            deb_lvl  <= 1'b0;
            press_q  <= 1'b0;
        end else begin
            tick_cnt <= tick_cnt_d;
            step_q   <= step_d;
            pat_q    <= pat_d;
            led_q    <= led_d;
            mode_q   <= mode_d;
            dir_q    <= dir_d;
            step_cnt <= step_cnt_d;
            sync_a   <= bus.BTN;
            sync_b   <= sync_a;
            deb_cnt  <= deb_cnt_d;
            deb_lvl  <= deb_lvl_d;
            press_q  <= press_d;
        end
    end

    assign bus.LED  = led_q;
    assign bus.MODE = mode_q;
    assign bus.STEP = step_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// ---------------------------------------------------------------------------
// tb_led_pattern_sequencer
//   Directed bench for led_pattern_sequencer with small dividers. A model
//   describes the pattern as a position index per mode and is compared with
//   the DUT after every rising edge; directed sections add literal checks.
// ---------------------------------------------------------------------------
module tb_led_pattern_sequencer;

    localparam int FAST = 4;
    localparam int SLOW = 8;
    localparam int DEB  = 3;
    localparam int SPM  = 4;

    logic CLK;
    logic RESET;

    led_pattern_sequencer_if bus_if();

    led_pattern_sequencer #(
        .FAST_DIV       (FAST),
        .SLOW_DIV       (SLOW),
        .DEB_CYCLES     (DEB),
        .STEPS_PER_MODE (SPM)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus_if)
    );

    int n_vec  = 0;
    int n_miss = 0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Pattern after idx steps in a mode, starting from 16'h0001.
    function automatic logic [15:0] exp_pat(input int mode, input int idx);
        logic [31:0] one;
        int k;
        one = 32'd1;
        k   = 0;
        case (mode)
            0: k = idx % 16;
            1: k = (16 - idx % 16) % 16;
            2: begin
                k = idx % 30;
                if (k > 15) k = 30 - k;
            end
            default: return 16'((one << (idx % 16 + 1)) - 32'd1);
        endcase
        return 16'(one << k);
    endfunction

    // -----------------------------------------------------------------------
    // Model and per-cycle compare
    // -----------------------------------------------------------------------
    initial begin : model
        int m_cnt, m_idx, m_mode, m_scnt, m_run, div;
        bit m_step, m_s1, m_s2, m_deb, m_press, tick, auto_adv, adv;
        logic [15:0] e_led;
        m_cnt = 0; m_idx = 0; m_mode = 0; m_scnt = 0; m_run = 0;
        m_step = 0; m_s1 = 0; m_s2 = 0; m_deb = 0; m_press = 0;
        forever begin
            @(posedge CLK);
            if (!RESET) begin
                m_cnt = 0; m_idx = 0; m_mode = 0; m_scnt = 0; m_run = 0;
                m_step = 0; m_s1 = 0; m_s2 = 0; m_deb = 0; m_press = 0;
            end else begin
                div      = bus_if.DIP[0] ? SLOW : FAST;
                tick     = !bus_if.PAUSE && (m_cnt >= div - 1);
                auto_adv = bus_if.DIP[1] && m_step && (m_scnt == SPM - 1);
                adv      = m_press || auto_adv;
                if (adv || !bus_if.DIP[1]) m_scnt = 0;
                else if (m_step)           m_scnt++;
                if (adv) begin
                    m_mode = (m_mode + 1) % 4;
                    m_idx  = 0;
                    m_cnt  = 0;
                end else if (!bus_if.PAUSE) begin
                    if (tick) begin
                        m_cnt = 0;
                        m_idx = (m_idx + 1) % 240;
                    end else begin
                        m_cnt++;
                    end
                end
                m_step  = tick && !adv;
                m_press = 0;
                if (m_s2 == m_deb) m_run = 0;
                else if (m_run == DEB - 1) begin
                    m_deb   = m_s2;
                    m_run   = 0;
                    m_press = m_s2;
                end else m_run++;
                m_s2 = m_s1;
                m_s1 = bus_if.BTN;
            end
            #1;
            e_led = ~exp_pat(m_mode, m_idx);
            chk("model_led",  32'(bus_if.LED),  32'(e_led));
            chk("model_mode", 32'(bus_if.MODE), 32'(m_mode));
            chk("model_step", 32'(bus_if.STEP), 32'(m_step));
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus helpers
    // -----------------------------------------------------------------------
    task automatic wait_step(input string name, input logic [15:0] exp_led);
        bit seen;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK);
            if (bus_if.STEP) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s: got no STEP in 40 cycles, expected a STEP", name);
        end else begin
            chk(name, 32'(bus_if.LED), 32'(exp_led));
        end
    endtask

    task automatic skip_steps(input int n);
        for (int i = 0; i < n; i++) begin
            bit seen;
            seen = 0;
            for (int k = 0; k < 40; k++) begin
                @(negedge CLK);
                if (bus_if.STEP) begin
                    seen = 1;
                    break;
                end
            end
            if (!seen) begin
                n_vec++;
                n_miss++;
                $display("FAIL skip_steps: got no STEP in 40 cycles, expected a STEP");
            end
        end
    endtask

    task automatic press_and_wait(input string name, input logic [1:0] exp_mode);
        bit seen;
        seen = 0;
        bus_if.BTN = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge CLK);
            if (k >= 6) bus_if.BTN = 1'b0;
            if (bus_if.MODE == exp_mode) begin
                seen = 1;
                break;
            end
        end
        bus_if.BTN = 1'b0;
        if (!seen) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s: got MODE %0d after 20 cycles, expected %0d", name, bus_if.MODE, exp_mode);
        end else begin
            chk(name, 32'(bus_if.LED), 32'h0000FFFE);
        end
    endtask

    task automatic first_step(input string name);
        for (int k = 1; k <= 4; k++) begin
            @(negedge CLK);
            chk(name, 32'(bus_if.STEP), (k == 4) ? 32'd1 : 32'd0);
        end
        chk({name, "_led"}, 32'(bus_if.LED), 32'h0000FFFD);
    endtask

    // -----------------------------------------------------------------------
    // Directed sequence
    // -----------------------------------------------------------------------
    initial begin : stim
        int steps;
        logic [1:0] prev;
        RESET        = 1'b0;
        bus_if.BTN   = 1'b0;
        bus_if.PAUSE = 1'b0;
        bus_if.DIP   = 2'b00;

        // Model pins
        chk("pin_rotr1",    32'(exp_pat(1, 1)),  32'h8000);
        chk("pin_bounce15", 32'(exp_pat(2, 15)), 32'h8000);
        chk("pin_bounce29", 32'(exp_pat(2, 29)), 32'h0002);
        chk("pin_fill15",   32'(exp_pat(3, 15)), 32'hFFFF);

        // Reset state and rotate-left
        @(negedge CLK);
        chk("rst_led",  32'(bus_if.LED),  32'h0000FFFE);
        chk("rst_mode", 32'(bus_if.MODE), 32'd0);
        chk("rst_step", 32'(bus_if.STEP), 32'd0);
        @(negedge CLK);
        RESET = 1'b1;
        first_step("first_step");
        wait_step("rotl2", 16'hFFFB);
        wait_step("rotl3", 16'hFFF7);
        wait_step("rotl4", 16'hFFEF);
        skip_steps(11);
        wait_step("rotl_wrap", 16'hFFFE);

        // Slow rate, then back to fast with the count past the fast limit
        bus_if.DIP = 2'b01;
        for (int k = 1; k <= 5; k++) begin
            @(negedge CLK);
            chk("slow_nostep", 32'(bus_if.STEP), 32'd0);
        end
        bus_if.DIP = 2'b00;
        @(negedge CLK);
        chk("dip_fast_tick", 32'(bus_if.STEP), 32'd1);
        chk("dip_fast_led",  32'(bus_if.LED),  32'h0000FFFD);
        for (int k = 1; k <= 4; k++) begin
            @(negedge CLK);
            chk("fast_period", 32'(bus_if.STEP), (k == 4) ? 32'd1 : 32'd0);
        end

        // Pause
        bus_if.PAUSE = 1'b1;
        steps = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            if (bus_if.STEP) steps++;
        end
        chk("pause_steps", 32'(steps), 32'd0);
        chk("pause_led",   32'(bus_if.LED), 32'h0000FFFB);
        bus_if.PAUSE = 1'b0;

        // Button glitch, then a real press into rotate-right
        bus_if.BTN = 1'b1;
        repeat (2) @(negedge CLK);
        bus_if.BTN = 1'b0;
        repeat (6) @(negedge CLK);
        chk("glitch_mode", 32'(bus_if.MODE), 32'd0);
        press_and_wait("btn_mode1", 2'd1);
        wait_step("rotr1", 16'h7FFF);
        wait_step("rotr2", 16'hBFFF);

        // Bounce
        press_and_wait("btn_mode2", 2'd2);
        skip_steps(14);
        wait_step("bounce_top",  16'h7FFF);
        wait_step("bounce_back", 16'hBFFF);
        skip_steps(13);
        wait_step("bounce_home", 16'hFFFE);

        // Fill
        press_and_wait("btn_mode3", 2'd3);
        wait_step("fill1", 16'hFFFC);
        wait_step("fill2", 16'hFFF8);
        skip_steps(12);
        wait_step("fill_full", 16'h0000);
        wait_step("fill_wrap", 16'hFFFE);

        // Auto-cycle 0->1->2->3->0
        press_and_wait("btn_mode0", 2'd0);
        bus_if.DIP = 2'b10;
        for (int m = 1; m <= 4; m++) begin
            bit changed;
            changed = 0;
            steps   = 0;
            prev    = bus_if.MODE;
            for (int k = 0; k < 60; k++) begin
                @(negedge CLK);
                if (bus_if.MODE != prev) begin
                    changed = 1;
                    break;
                end
                if (bus_if.STEP) steps++;
            end
            if (!changed) begin
                n_vec++;
                n_miss++;
                $display("FAIL auto_adv: got no MODE change in 60 cycles, expected one");
            end
            chk("auto_steps", 32'(steps), 32'd4);
            chk("auto_mode",  32'(bus_if.MODE), 32'(m % 4));
        end

        // Press landing in the same cycle as the auto-advance
        repeat (11) @(negedge CLK);
        bus_if.BTN = 1'b1;
        repeat (5) @(negedge CLK);
        chk("coinc_step",   32'(bus_if.STEP), 32'd1);
        chk("coinc_before", 32'(bus_if.MODE), 32'd0);
        @(negedge CLK);
        bus_if.BTN = 1'b0;
        chk("coinc_after",  32'(bus_if.MODE), 32'd1);
        repeat (3) @(negedge CLK);
        chk("coinc_single", 32'(bus_if.MODE), 32'd1);
        bus_if.DIP = 2'b00;
        repeat (8) @(negedge CLK);

        // Reset in the middle of bounce
        press_and_wait("btn_mode2b", 2'd2);
        skip_steps(3);
        @(negedge CLK);
        #2 RESET = 1'b0;
        #1;
        chk("midrst_led",  32'(bus_if.LED),  32'h0000FFFE);
        chk("midrst_mode", 32'(bus_if.MODE), 32'd0);
        chk("midrst_step", 32'(bus_if.STEP), 32'd0);
        @(negedge CLK);
        RESET = 1'b1;
        first_step("post_rst_step");
        chk("post_rst_mode", 32'(bus_if.MODE), 32'd0);
        repeat (4) @(negedge CLK);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no end of test by 200000, expected earlier end");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/led_pattern_sequencer.md
Name: led_pattern_sequencer

Overview:
- Single-clock LED pattern controller for the 16-LED board bank.
- Generates the step-rate tick internally as a clock enable, with no derived clocks.
- Selects among four pattern modes, advanced by a debounced push-button or automatically after a fixed number of steps.
- Drives the active-low LED bank directly; DIP switches select step speed and auto-cycle.

Parameters:
- FAST_DIV, 2097152: CLK cycles per step when DIP[0]=0; must be >= 2.
- SLOW_DIV, 8388608: CLK cycles per step when DIP[0]=1; must be >= 2.
- DEB_CYCLES, 65536: consecutive stable synchronized cycles needed to accept a new button level.
- STEPS_PER_MODE, 32: steps per mode before an auto-advance; must be >= 1.

Ports:
- CLK  input  1  system clock.
- RESET  input  1  asynchronous, active-low reset.
- BTN  input  1  asynchronous active-high push-button, mode advance.
- PAUSE  input  1  synchronous; 1 freezes the tick counter and pattern.
- DIP  input  2  DIP[0]: 0=FAST_DIV, 1=SLOW_DIV; DIP[1]: 1=auto-cycle enable.
- LED  output  16  active-low LED drive, LED = ~P.
- MODE  output  2  current mode: 0=ROT_L, 1=ROT_R, 2=BOUNCE, 3=FILL.
- STEP  output  1  one-CLK pulse on each pattern update.

Behaviour:
- Reset values: RESET is asynchronous, active-low; clock is CLK.
  - P=16'h0001, so LED=16'hFFFE.
  - MODE=0, STEP=0, bounce dir=L.
  - Tick counter, step counter, synchronizer, debounce counter and debounced level all 0.
- All outputs are registered.
- Tick counter: DIV = DIP[0] ? SLOW_DIV : FAST_DIV, sampled every cycle.
  - Increments each cycle while PAUSE=0.
  - When count >= DIV-1: tick asserted, count <= 0. This also covers a DIP[0] change to a smaller DIV while the count is above the new limit.
  - PAUSE=1: count holds, no tick, P holds.
- STEP equals the registered tick, so P, LED and STEP all update in the cycle after the tick condition.
- Pattern update on tick:
  - ROT_L: P <= {P[14:0],P[15]}.
  - ROT_R: P <= {P[0],P[15:1]}.
  - BOUNCE:
    - dir=L and P[15]=1: dir <= R, P <= P>>1.
    - dir=R and P[0]=1: dir <= L, P <= P<<1.
    - Otherwise shift one place per dir.
    - Period is 30 steps.
  - FILL: P == 16'hFFFF ? 16'h0001 : {P[14:0],1'b1}. Period is 16 steps.
- Button path:
  - 2-FF synchronizer into the debounce counter.
  - Counter clears whenever sync == debounced level.
  - Otherwise counter increments; on reaching DEB_CYCLES-1, debounced level <= sync and counter clears.
  - Press event = debounced 0->1 transition, one cycle wide.
- Mode advance, from a press or an auto-advance:
  - MODE <= MODE+1, wrapping 3->0.
  - P <= 16'h0001, dir <= L.
  - Step counter <= 0, tick counter <= 0.
  - Takes effect the cycle after the event.
  - Advance overrides a coincident tick: the tick is dropped and STEP stays 0.
  - PAUSE does not block a button advance.
- Auto-cycle (DIP[1]=1):
  - Step counter increments on each STEP.
  - Reaching STEPS_PER_MODE generates an advance on the following cycle, and the step counter clears.
  - A press coincident with an auto-advance produces a single advance, not two.
  - DIP[1]=0: step counter held at 0.
- Reset mid-operation returns everything to reset values immediately (asynchronous); the first tick arrives DIV cycles after release.

Test Plan (FAST_DIV=4, SLOW_DIV=8, DEB_CYCLES=3, STEPS_PER_MODE=4):
- Reset, DIP=00 -> LED=FFFE, MODE=0. STEP pulses every 4 cycles; LED sequence FFFD, FFFB, FFF7, ... ; after 16 steps LED returns to FFFE.
- DIP[0]=1 while count=5 of 8, then DIP[0]=0 -> tick on the next cycle, then every 4 cycles. PAUSE=1 for 10 cycles -> no STEP, LED unchanged.
- BTN glitch high for 2 cycles -> MODE stays 0. BTN held for 6 cycles -> MODE=1, LED=FFFE; subsequent steps give LED 7FFF, BFFF.
- MODE=2 -> P walks 0001 to 8000 (15 steps), then 4000; returns to 0001 after 30 steps. MODE=3 -> P goes 0003, 0007, ..., FFFF, then 0001.
- DIP[1]=1 -> MODE advances 0->1->2->3->0, every 4 steps each. Press coincident with an auto-advance -> exactly one increment.
- RESET asserted mid-BOUNCE -> LED=FFFE and MODE=0 in the same cycle; release -> first STEP 4 cycles later.
